// File: rtl/gemm_tile_controller.sv
// Tile sequencer for the GeMM datapath: walks m/n/k tile loops, drives A/B read addresses,
// MAC valid/clear strobes and C write strobe/address through a three-stage pipeline.
module gemm_tile_controller #(
    parameter int unsigned M             = 4,
    parameter int unsigned N             = 4,
    parameter int unsigned K             = 4,
    parameter int unsigned AddrWidth     = 6,
    parameter int unsigned SizeAddrWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     mac_valid_o,
    output logic                     mac_clear_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned LogM = $clog2(M);
    localparam int unsigned LogN = $clog2(N);
    localparam int unsigned LogK = $clog2(K);
    localparam int unsigned SW   = SizeAddrWidth;
    localparam int unsigned AW   = AddrWidth;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] mt_q, mt_d, kt_q, kt_d, nt_q, nt_d;
    logic [SW-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
    logic          issuing_q, issuing_d;
    logic [AW-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic          valid_q, valid_d, clear_q, clear_d, last_q, last_d;
    logic [AW-1:0] c_pend_q, c_pend_d, c_addr_q, c_addr_d;
    logic          we_q, we_d, busy_q, busy_d, done_q, done_d;

    logic [SW-1:0] mt_new, kt_new, nt_new;
    logic [SW-1:0] m_nx, n_nx, k_nx;
    logic          last_k, last_n, last_m, final_issue;

    always_comb begin
        mt_new = M_size_i >> LogM;
        kt_new = K_size_i >> LogK;
        nt_new = N_size_i >> LogN;

        last_k      = (k_q == kt_q - SW'(1));
        last_n      = (n_q == nt_q - SW'(1));
        last_m      = (m_q == mt_q - SW'(1));
        final_issue = issuing_q & last_k & last_n & last_m;

        m_nx = m_q;
        n_nx = n_q;
        k_nx = k_q + SW'(1);
        if (last_k) begin
            k_nx = '0;
            n_nx = n_q + SW'(1);
            if (last_n) begin
                n_nx = '0;
                m_nx = m_q + SW'(1);
            end
        end

        state_d   = state_q;
        mt_d      = mt_q;
        kt_d      = kt_q;
        nt_d      = nt_q;
        m_d       = m_q;
        n_d       = n_q;
        k_d       = k_q;
        issuing_d = issuing_q;
        a_addr_d  = a_addr_q;
        b_addr_d  = b_addr_q;

        // Stage 1 and stage 2 are pure pipeline registers behind the issue stage.
        // Products are formed at AddrWidth, which equals truncating the full-width product.
        valid_d  = issuing_q;
        clear_d  = issuing_q & (k_q == '0);
        last_d   = issuing_q & last_k;
        c_pend_d = AW'(m_q) * AW'(nt_q) + AW'(n_q);
        we_d     = valid_q & last_q;
        c_addr_d = (valid_q & last_q) ? c_pend_q : '0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mt_d = mt_new;
                    kt_d = kt_new;
                    nt_d = nt_new;
                    m_d  = '0;
                    n_d  = '0;
                    k_d  = '0;
                    a_addr_d = '0;
                    b_addr_d = '0;
                    if (mt_new == '0 || kt_new == '0 || nt_new == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StRun;
                        issuing_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (issuing_q) begin
                    m_d = m_nx;
                    n_d = n_nx;
                    k_d = k_nx;
                    if (final_issue) begin
                        issuing_d = 1'b0;
                        a_addr_d  = '0;
                        b_addr_d  = '0;
                    end else begin
                        a_addr_d = AW'(m_nx) * AW'(kt_q) + AW'(k_nx);
                        b_addr_d = AW'(k_nx) * AW'(nt_q) + AW'(n_nx);
                    end
                end else if (!valid_q) begin
                    // Stage 1 empty means the final write is on the outputs this cycle.
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            mt_q      <= '0;
            kt_q      <= '0;
            nt_q      <= '0;
            m_q       <= '0;
            n_q       <= '0;
            k_q       <= '0;
            issuing_q <= 1'b0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            valid_q   <= 1'b0;
            clear_q   <= 1'b0;
            last_q    <= 1'b0;
            c_pend_q  <= '0;
            c_addr_q  <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mt_q      <= mt_d;
            kt_q      <= kt_d;
            nt_q      <= nt_d;
            m_q       <= m_d;
            n_q       <= n_d;
            k_q       <= k_d;
            issuing_q <= issuing_d;
            a_addr_q  <= a_addr_d;
            b_addr_q  <= b_addr_d;
            valid_q   <= valid_d;
            clear_q   <= clear_d;
            last_q    <= last_d;
            c_pend_q  <= c_pend_d;
            c_addr_q  <= c_addr_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sram_a_addr_o = a_addr_q;
    assign sram_b_addr_o = b_addr_q;
    assign sram_c_addr_o = c_addr_q;
    assign sram_c_we_o   = we_q;
    assign mac_valid_o   = valid_q;
    assign mac_clear_o   = clear_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
